// File: rtl/press_duration_decoder_pkg.sv
// Shared types and default constants for the press-duration decoder and its
// debouncer (which is also used by the random-seconds LED block).
package press_decoder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned CLK_HZ              = 32'd25_000_000;
    localparam int unsigned DEF_TICK_CYCLES     = CLK_HZ;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = CLK_HZ / 32'd100;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_bits(input int unsigned n);
        if (n <= 32'd1) begin
            return 32'd1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/press_duration_decoder_btn_debounce.sv
// Button conditioner: 2-FF synchroniser followed by a stable-sample counter.
// The output only follows the input after DEBOUNCE_CYCLES identical samples.
module btn_debounce
    import press_decoder_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    localparam int unsigned     CW       = cnt_bits(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 32'd1);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(32'd1);

    logic          r_sync0;
    logic          r_sync1;
    logic          r_deb;
    logic [CW-1:0] r_cnt;

    // Synchronise the raw input and accept a new level once it has been stable long enough.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync0 <= 1'b0;
            r_sync1 <= 1'b0;
            r_deb   <= 1'b0;
            r_cnt   <= {CW{1'b0}};
        end else begin
            r_sync0 <= din;
            r_sync1 <= r_sync0;
            if (r_sync1 == r_deb) begin
                r_cnt <= {CW{1'b0}};
            end else if (r_cnt == CNT_LAST) begin
                r_deb <= r_sync1;
                r_cnt <= {CW{1'b0}};
            end else begin
                r_cnt <= r_cnt + CNT_ONE;
            end
        end
    end

    assign dout = r_deb;

endmodule

// File: rtl/press_duration_decoder.sv
// Measures how many whole seconds the button is held and latches the count on
// release. Optional macro PRESS_ROUND_EN rounds to the nearest second instead.
module press_duration_decoder
    import press_decoder_pkg::*;
#(
    parameter int unsigned TICK_CYCLES     = DEF_TICK_CYCLES,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W           = 32'd4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_raw,
    output logic             led_onboard,
    output logic [CNT_W-1:0] led_ext,
    output logic [CNT_W-1:0] result,
    output logic             result_valid,
    output logic             holding
);

    localparam int unsigned      TW        = cnt_bits(TICK_CYCLES);
    localparam logic [TW-1:0]    TICK_LAST = TW'(TICK_CYCLES - 32'd1);
    localparam logic [TW-1:0]    TICK_ONE  = TW'(32'd1);
    localparam int unsigned      AW        = cnt_bits(DEBOUNCE_CYCLES + 32'd3);
    localparam logic [AW-1:0]    ARM_LAST  = AW'(DEBOUNCE_CYCLES + 32'd2);
    localparam logic [AW-1:0]    ARM_ONE   = AW'(32'd1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(32'd1);

    logic             w_deb;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_final;

    state_t           r_state;
    logic [TW-1:0]    r_tick;
    logic [CNT_W-1:0] r_sec;
    logic [CNT_W-1:0] r_result;
    logic             r_valid;
    logic             r_holding;
    logic             r_armed;
    logic [AW-1:0]    r_arm_cnt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == CNT_MAX) begin
            return v;
        end else begin
            return v + CNT_ONE;
        end
    endfunction

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk  (clk),
        .rst  (rst),
        .din  (btn_raw),
        .dout (w_deb)
    );

    // Arm only after the debounced level has stayed low longer than a press takes
    // to register, so a button held through reset is ignored until released.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_armed   <= 1'b0;
            r_arm_cnt <= {AW{1'b0}};
        end else if (w_deb) begin
            r_arm_cnt <= {AW{1'b0}};
        end else if (r_arm_cnt == ARM_LAST) begin
            r_armed <= 1'b1;
        end else begin
            r_arm_cnt <= r_arm_cnt + ARM_ONE;
        end
    end

`ifdef PRESS_ROUND_EN
    localparam logic [TW-1:0] TICK_HALF = TW'(TICK_CYCLES / 32'd2);

    // Round to nearest: a second that is at least half elapsed counts.
    always_comb begin
        w_final = r_sec;
        if (r_tick >= TICK_HALF) begin
            w_final = sat_inc(r_sec);
        end else begin
            w_final = r_sec;
        end
    end
`else
    // Truncate: only whole seconds count.
    always_comb begin
        w_final = r_sec;
    end
`endif

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (r_armed && w_deb) begin
                    w_state_nxt = HOLD;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            HOLD: begin
                if (!w_deb) begin
                    w_state_nxt = DONE;
                end else begin
                    w_state_nxt = HOLD;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Second counting and result latch. The result is captured on the HOLD->DONE
    // edge so it is already stable during the single DONE cycle that carries valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_tick    <= {TW{1'b0}};
            r_sec     <= {CNT_W{1'b0}};
            r_result  <= {CNT_W{1'b0}};
            r_valid   <= 1'b0;
            r_holding <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_holding <= (w_state_nxt == HOLD);
            r_valid   <= 1'b0;
            case (r_state)
                HOLD: begin
                    if (!w_deb) begin
                        r_result <= w_final;
                        r_valid  <= 1'b1;
                    end else if (r_tick == TICK_LAST) begin
                        r_tick <= {TW{1'b0}};
                        r_sec  <= sat_inc(r_sec);
                    end else begin
                        r_tick <= r_tick + TICK_ONE;
                    end
                end
                default: begin
                    r_tick <= {TW{1'b0}};
                    r_sec  <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    assign led_onboard  = w_deb;
    assign led_ext      = r_result;
    assign result       = r_result;
    assign result_valid = r_valid;
    assign holding      = r_holding;

endmodule

// File: tb/tb_press_duration_decoder.sv
// Directed bench for press_duration_decoder with TICK_CYCLES=100, DEBOUNCE_CYCLES=4.
module tb_press_duration_decoder;

    localparam int TICK = 100;
    localparam int DEB  = 4;
    localparam int CW   = 4;

`ifdef PRESS_ROUND_EN
    localparam int PRESS_LEN = 360;
    localparam int PRESS_EXP = 4;
    localparam int BND_EXP   = 3;
`else
    localparam int PRESS_LEN = 350;
    localparam int PRESS_EXP = 3;
    localparam int BND_EXP   = 2;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          btn_raw;
    logic          led_onboard;
    logic [CW-1:0] led_ext;
    logic [CW-1:0] result;
    logic          result_valid;
    logic          holding;

    int n_checks = 0;
    int n_pass   = 0;
    int valid_cnt = 0;
    int hold_entries = 0;
    logic hold_prev = 1'b0;

    press_duration_decoder #(
        .TICK_CYCLES     (TICK),
        .DEBOUNCE_CYCLES (DEB),
        .CNT_W           (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_raw      (btn_raw),
        .led_onboard  (led_onboard),
        .led_ext      (led_ext),
        .result       (result),
        .result_valid (result_valid),
        .holding      (holding)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (result_valid === 1'b1) valid_cnt <= valid_cnt + 1;
        if (holding === 1'b1 && hold_prev !== 1'b1) hold_entries <= hold_entries + 1;
        hold_prev <= holding;
    end

    task automatic release_and_wait(output logic got);
        btn_raw = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (result_valid === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        btn_raw = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({led_onboard, led_ext, result, result_valid, holding} !== 11'd0)
            $display("FAIL reset_outputs: got %b expected 0", {led_onboard, led_ext, result, result_valid, holding});
        else n_pass++;
        rst = 1'b0;
        repeat (10) @(negedge clk);
        n_checks++;
        if (holding !== 1'b0 || valid_cnt !== 0)
            $display("FAIL reset_idle: holding %b valids %0d expected 0/0", holding, valid_cnt);
        else n_pass++;
    endtask

    task automatic test_held_through_reset;
        int v0;
        logic got;
        btn_raw = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        v0 = valid_cnt;
        repeat (60) @(negedge clk);
        n_checks++;
        if (holding !== 1'b0) $display("FAIL held_reset_no_hold: holding %b expected 0", holding);
        else n_pass++;
        n_checks++;
        if (led_onboard !== 1'b1) $display("FAIL held_reset_led: led_onboard %b expected 1", led_onboard);
        else n_pass++;
        btn_raw = 1'b0;
        repeat (20) @(negedge clk);
        n_checks++;
        if (led_onboard !== 1'b0 || valid_cnt !== v0)
            $display("FAIL held_reset_release: led %b valids %0d expected 0/%0d", led_onboard, valid_cnt, v0);
        else n_pass++;
        btn_raw = 1'b1;
        repeat (20) @(negedge clk);
        n_checks++;
        if (holding !== 1'b1) $display("FAIL held_reset_repress: holding %b expected 1", holding);
        else n_pass++;
        repeat (130) @(negedge clk);
        release_and_wait(got);
        n_checks++;
        if (got !== 1'b1 || result !== 4'd1)
            $display("FAIL held_reset_result: valid %b result %0d expected 1/1", got, result);
        else n_pass++;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_press;
        int v0;
        logic got;
        v0 = valid_cnt;
        btn_raw = 1'b1;
        repeat (PRESS_LEN) @(negedge clk);
        release_and_wait(got);
        n_checks++;
        if (got !== 1'b1) $display("FAIL press_timeout: valid %b expected 1", got);
        else n_pass++;
        n_checks++;
        if (result !== PRESS_EXP[CW-1:0] || led_ext !== PRESS_EXP[CW-1:0])
            $display("FAIL press_result: result %0d led_ext %0d expected %0d", result, led_ext, PRESS_EXP);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (result_valid !== 1'b0) $display("FAIL press_pulse_width: valid %b expected 0", result_valid);
        else n_pass++;
        repeat (10) @(negedge clk);
        n_checks++;
        if (valid_cnt - v0 !== 1) $display("FAIL press_pulse_count: got %0d expected 1", valid_cnt - v0);
        else n_pass++;
    endtask

    task automatic test_bounce;
        int v0;
        int h0;
        logic got;
        v0 = valid_cnt;
        h0 = hold_entries;
        for (int i = 0; i < 5; i++) begin
            btn_raw = 1'b1;
            repeat (2) @(negedge clk);
            btn_raw = 1'b0;
            repeat (2) @(negedge clk);
        end
        n_checks++;
        if (led_onboard !== 1'b0) $display("FAIL bounce_filtered: led %b expected 0", led_onboard);
        else n_pass++;
        btn_raw = 1'b1;
        repeat (250) @(negedge clk);
        release_and_wait(got);
        n_checks++;
        if (got !== 1'b1 || result !== 4'd2)
            $display("FAIL bounce_result: valid %b result %0d expected 1/2", got, result);
        else n_pass++;
        repeat (10) @(negedge clk);
        n_checks++;
        if (hold_entries - h0 !== 1 || valid_cnt - v0 !== 1)
            $display("FAIL bounce_counts: holds %0d valids %0d expected 1/1", hold_entries - h0, valid_cnt - v0);
        else n_pass++;
    endtask

    task automatic test_glitch;
        int v0;
        logic [CW-1:0] r0;
        logic seen;
        v0 = valid_cnt;
        r0 = result;
        seen = 1'b0;
        btn_raw = 1'b1;
        repeat (3) @(negedge clk);
        btn_raw = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (led_onboard !== 1'b0) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) $display("FAIL glitch_deb: deb rose %b expected 0", seen);
        else n_pass++;
        n_checks++;
        if (valid_cnt !== v0 || result !== r0 || holding !== 1'b0)
            $display("FAIL glitch_effect: valids %0d result %0d holding %b expected %0d/%0d/0",
                     valid_cnt - v0, result, holding, 0, r0);
        else n_pass++;
    endtask

    task automatic test_saturate;
        logic got;
        btn_raw = 1'b1;
        repeat (2000) @(negedge clk);
        n_checks++;
        if (holding !== 1'b1) $display("FAIL sat_holding: holding %b expected 1", holding);
        else n_pass++;
        release_and_wait(got);
        n_checks++;
        if (got !== 1'b1 || result !== 4'd15 || led_ext !== 4'd15)
            $display("FAIL sat_result: valid %b result %0d led %0d expected 1/15/15", got, result, led_ext);
        else n_pass++;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_boundary;
        logic got;
        btn_raw = 1'b1;
        repeat (300) @(negedge clk);
        release_and_wait(got);
        n_checks++;
        if (got !== 1'b1 || result !== BND_EXP[CW-1:0])
            $display("FAIL boundary_300: valid %b result %0d expected 1/%0d", got, result, BND_EXP);
        else n_pass++;
        repeat (10) @(negedge clk);
        btn_raw = 1'b1;
        repeat (301) @(negedge clk);
        release_and_wait(got);
        n_checks++;
        if (got !== 1'b1 || result !== 4'd3)
            $display("FAIL boundary_301: valid %b result %0d expected 1/3", got, result);
        else n_pass++;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_reset_midpress;
        int v0;
        logic got;
        v0 = valid_cnt;
        btn_raw = 1'b1;
        repeat (150) @(negedge clk);
        n_checks++;
        if (holding !== 1'b1) $display("FAIL midpress_holding: holding %b expected 1", holding);
        else n_pass++;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (holding !== 1'b0 || result !== 4'd0 || led_ext !== 4'd0)
            $display("FAIL midpress_reset: holding %b result %0d led %0d expected 0/0/0", holding, result, led_ext);
        else n_pass++;
        rst = 1'b0;
        repeat (100) @(negedge clk);
        n_checks++;
        if (holding !== 1'b0) $display("FAIL midpress_no_rearm: holding %b expected 0", holding);
        else n_pass++;
        btn_raw = 1'b0;
        repeat (30) @(negedge clk);
        n_checks++;
        if (valid_cnt !== v0 || result !== 4'd0)
            $display("FAIL midpress_discard: valids %0d result %0d expected 0/0", valid_cnt - v0, result);
        else n_pass++;
        btn_raw = 1'b1;
        repeat (120) @(negedge clk);
        release_and_wait(got);
        n_checks++;
        if (got !== 1'b1 || result !== 4'd1)
            $display("FAIL midpress_recover: valid %b result %0d expected 1/1", got, result);
        else n_pass++;
    endtask

    initial begin
        rst = 1'b1;
        btn_raw = 1'b0;
        test_reset;
        test_held_through_reset;
        test_press;
        test_bounce;
        test_glitch;
        test_saturate;
        test_boundary;
        test_reset_midpress;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/press_duration_decoder.md
Name: press_duration_decoder

Overview:
Companion to the random-seconds LED block, working in the opposite direction. That block turns a random number into an LED on-time; this block measures how long the button is held and turns that duration back into a number. It debounces btn_raw, counts whole seconds of stable press, and latches the count on release. The count is shown in binary on the external LEDs and presented on a result/valid interface for downstream logic.

Parameters:
TICK_CYCLES, 25_000_000, clk cycles per counted second (1 s at 25 MHz)
DEBOUNCE_CYCLES, 250_000, consecutive stable samples required to accept a level change (10 ms)
CNT_W, 4, width of the seconds count and of led_ext

Ports:
clk  input  1  system clock, 25 MHz
rst  input  1  synchronous reset, active-high
btn_raw  input  1  asynchronous, bouncing pushbutton, 1 = pressed
led_onboard  output  1  debounced button level (lit while press is accepted)
led_ext  output  CNT_W  last latched result, binary
result  output  CNT_W  last latched seconds count
result_valid  output  1  one-cycle pulse when result updates
holding  output  1  1 while FSM in HOLD

Behaviour:
- Reset (rst=1 at a clk edge):
  - sync FFs, debounced level, debounce counter, tick counter and sec_cnt cleared to 0.
  - result, led_ext, result_valid, holding, led_onboard = 0; FSM = IDLE.
  - Reset mid-press discards the measurement.
  - After reset, a button still held must first be seen as released before a new press counts.
- Synchroniser: 2-FF on btn_raw; output s.
- Debounce:
  - cnt clears whenever s == deb.
  - Otherwise cnt increments; when cnt reaches DEBOUNCE_CYCLES-1, deb <= s and cnt <= 0.
  - Raw edge to deb change: DEBOUNCE_CYCLES+2 cycles for a clean edge.
  - Bounces shorter than DEBOUNCE_CYCLES are ignored.
- led_onboard = deb (registered).
- FSM states IDLE, HOLD, DONE:
  - IDLE: tick=0, sec_cnt=0. deb rising -> HOLD.
  - HOLD: holding=1.
    - tick counts 0..TICK_CYCLES-1; on tick==TICK_CYCLES-1, tick <= 0 and sec_cnt += 1.
    - sec_cnt saturates at 2**CNT_W-1; further ticks do not wrap.
    - deb falling -> DONE. On that same cycle the tick increment is suppressed, so a release coincident with a boundary does not count that second.
  - DONE: result <= sec_cnt, led_ext <= sec_cnt, result_valid=1 for exactly this cycle; -> IDLE.
- Latency: result_valid is high 1 cycle after the deb falling edge.
- Press shorter than 1 s: result 0, result_valid still pulses.
- deb is never high in DONE, because a press needs DEBOUNCE_CYCLES to register; a new press starts from IDLE.
- result and led_ext hold their value until the next DONE or reset.

Optional Feature:
Macro PRESS_ROUND_EN.
- Defined: in DONE, if tick >= TICK_CYCLES/2, result = sec_cnt+1, saturating at 2**CNT_W-1. This is round-to-nearest.
- Undefined: result = sec_cnt, i.e. floor/truncation.
- Port list is identical either way.

Decomposition:
- Package press_decoder_pkg holds:
  - state_t enum {IDLE, HOLD, DONE};
  - default constants CLK_HZ=25_000_000, DEF_TICK_CYCLES, DEF_DEBOUNCE_CYCLES.
- One sub-module btn_debounce (params DEBOUNCE_CYCLES; ports clk, rst, din, dout):
  - contains the 2-FF synchroniser and the debounce counter;
  - reusable by the random-seconds block.

Test Plan:
Bench params for all scenarios: TICK_CYCLES=100, DEBOUNCE_CYCLES=4, CNT_W=4.
1. Reset check: rst high 3 cycles -> all outputs 0. Then btn_raw held 1 during and after reset -> holding rises only after a release/press cycle.
2. Press held 350 cycles -> result_valid single pulse, result=3, led_ext=3. With PRESS_ROUND_EN -> result=4.
3. Bounce: btn_raw toggles every 2 cycles for 20 cycles, then stable 1 for 250 cycles, then released -> one HOLD entry, one result_valid, result=2.
4. Short glitch: 3-cycle pulse on btn_raw -> deb stays 0, no result_valid, result unchanged.
5. Saturation: press held 2000 cycles -> result=15; sec_cnt never wraps to 0.
6. Boundary: release timed so the deb fall coincides with tick==99 after 2 full seconds -> result=2, not 3. Follow with rst asserted mid-press -> no result_valid, result=0.
